register_bank: RTL and testbench

Parametrised bank of Z80-writable registers, successor to the single 8-bit data register. Holds `DEPTH` registers of `WIDTH` bits each. Supports read-modify-write modes, edge-detected strobes, a registered readback path, and per-register "changed" flags for downstream consumers. Sits between the Z80 bus interface (address decode to bank level, strobes aligned to `clk`) and the peripheral logic, which consumes the flat contents bus.

---
 rtl/register_bank.sv | 141 ++++++++++++++
 tb/tb_register_bank.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/register_bank.sv
`default_nettype none
// ============================================================================
// Module   : register_bank
// Purpose  : Bank of DEPTH Z80-writable registers, WIDTH bits each.
//            Edge-detected write/read strobes, read-modify-write modes
//            (load / set / clear / toggle), registered readback and
//            sticky per-register "changed" flags.
//            Optional feature macro: REGISTER_BANK_CHANGE_FLAGS_EN
//            (defined: changed/changed_ack active; undefined: changed = 0).
// Revision : 1.0 - initial release
// ============================================================================
module register_bank #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   write_strobe,
    input  logic                   read_strobe,
    input  logic [ADDR_W-1:0]      addr,
    input  logic [1:0]             mode,
    input  logic [WIDTH-1:0]       data_in,
    output logic [WIDTH-1:0]       read_data,
    output logic [WIDTH*DEPTH-1:0] contents,
    output logic [DEPTH-1:0]       changed,
    input  logic [DEPTH-1:0]       changed_ack
);

    localparam logic [1:0] c_MODE_LOAD  = 2'b00;
    localparam logic [1:0] c_MODE_SET   = 2'b01;
    localparam logic [1:0] c_MODE_CLEAR = 2'b10;
    localparam logic [1:0] c_MODE_TOGGLE = 2'b11;

    logic [WIDTH-1:0] r_regs [DEPTH];
    logic             r_ws_prev;
    logic             r_rs_prev;
    logic [WIDTH-1:0] r_read_data;

    logic             w_write_fire;
    logic             w_read_fire;
    logic [WIDTH-1:0] w_sel_val;
    logic [WIDTH-1:0] w_new_val;

    assign w_write_fire = write_strobe & ~r_ws_prev;
    assign w_read_fire  = read_strobe  & ~r_rs_prev;

    // Previous-strobe samples; forced high in reset so a strobe held across
    // reset release is not mistaken for a fresh rising edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ws_prev <= 1'b1;
            r_rs_prev <= 1'b1;
        end else begin
            r_ws_prev <= write_strobe;
            r_rs_prev <= read_strobe;
        end
    end

    // Currently addressed register value; zero for unmapped addresses.
    always_comb begin
        w_sel_val = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (addr == ADDR_W'(i)) begin
                w_sel_val = r_regs[i];
            end
        end
    end

    // Read-modify-write result for the addressed register.
    always_comb begin
        w_new_val = data_in;
        case (mode)
            c_MODE_LOAD:   w_new_val = data_in;
            c_MODE_SET:    w_new_val = w_sel_val | data_in;
            c_MODE_CLEAR:  w_new_val = w_sel_val & ~data_in;
            c_MODE_TOGGLE: w_new_val = w_sel_val ^ data_in;
            default:       w_new_val = data_in;
        endcase
    end

    // Register storage: only the addressed register updates on a write fire.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_write_fire) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (addr == ADDR_W'(i)) begin
                    r_regs[i] <= w_new_val;
                end
            end
        end
    end

    // Readback captures the pre-write value, so a same-cycle write is not seen.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_read_data <= '0;
        end else if (w_read_fire) begin
            r_read_data <= w_sel_val;
        end
    end

    assign read_data = r_read_data;

    generate
        for (genvar g = 0; g < DEPTH; g++) begin : g_flat
            assign contents[g*WIDTH +: WIDTH] = r_regs[g];
        end
    endgenerate

`ifdef REGISTER_BANK_CHANGE_FLAGS_EN
    logic [DEPTH-1:0] r_changed;

    // Sticky changed flags: a value-altering write sets, ack clears, set wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_changed <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_write_fire && (addr == ADDR_W'(i)) && (w_new_val != r_regs[i])) begin
                    r_changed[i] <= 1'b1;
                end else if (changed_ack[i]) begin
                    r_changed[i] <= 1'b0;
                end
            end
        end
    end

    assign changed = r_changed;
`else
    // Flag logic absent: acknowledge input is intentionally left unconsumed.
    logic w_unused_ack;
    assign w_unused_ack = ^changed_ack;
    assign changed      = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_register_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_register_bank
// Purpose  : Directed self-checking bench for register_bank (DEPTH=3).
//            Expected "changed" values follow REGISTER_BANK_CHANGE_FLAGS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_register_bank;

    localparam int WIDTH  = 8;
    localparam int DEPTH  = 3;
    localparam int ADDR_W = 2;
`ifdef REGISTER_BANK_CHANGE_FLAGS_EN
    localparam bit c_FL = 1'b1;
`else
    localparam bit c_FL = 1'b0;
`endif
    localparam logic [DEPTH-1:0] c_FMASK = {DEPTH{c_FL}};

    logic                   clk;
    logic                   reset;
    logic                   write_strobe;
    logic                   read_strobe;
    logic [ADDR_W-1:0]      addr;
    logic [1:0]             mode;
    logic [WIDTH-1:0]       data_in;
    logic [WIDTH-1:0]       read_data;
    logic [WIDTH*DEPTH-1:0] contents;
    logic [DEPTH-1:0]       changed;
    logic [DEPTH-1:0]       changed_ack;

    int r_total = 0;
    int r_bad   = 0;

    register_bank #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_dut (
        .clk          (clk),
        .reset        (reset),
        .write_strobe (write_strobe),
        .read_strobe  (read_strobe),
        .addr         (addr),
        .mode         (mode),
        .data_in      (data_in),
        .read_data    (read_data),
        .contents     (contents),
        .changed      (changed),
        .changed_ack  (changed_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        r_total++;
        if (got !== exp) begin
            r_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [1:0] m, input logic [WIDTH-1:0] d);
        addr = a; mode = m; data_in = d; write_strobe = 1'b1;
        tick();
        write_strobe = 1'b0;
        tick();
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] a);
        addr = a; read_strobe = 1'b1;
        tick();
        read_strobe = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1; write_strobe = 1'b0; read_strobe = 1'b0;
        addr = '0; mode = 2'b00; data_in = '0; changed_ack = '0;
        tick(); tick();
        reset = 1'b0;
        tick();
        check("reset_contents", 32'(contents), 32'h0);
        check("reset_read_data", 32'(read_data), 32'h0);
        check("reset_changed", 32'(changed), 32'h0);

        // Held strobe writes exactly once
        addr = 2'd1; mode = 2'b00; data_in = 8'h5A; write_strobe = 1'b1;
        tick();
        check("hold_first", 32'(contents[15:8]), 32'h5A);
        check("hold_changed", 32'(changed), 32'(c_FMASK & 3'b010));
        data_in = 8'h33;
        for (int k = 0; k < 9; k++) tick();
        check("hold_once", 32'(contents[15:8]), 32'h5A);
        write_strobe = 1'b0;
        tick();

        // Read-modify-write modes on reg 2
        do_write(2'd2, 2'b00, 8'hF0);
        check("load", 32'(contents[23:16]), 32'hF0);
        do_write(2'd2, 2'b01, 8'h0F);
        check("set", 32'(contents[23:16]), 32'hFF);
        do_write(2'd2, 2'b10, 8'h3C);
        check("clear", 32'(contents[23:16]), 32'hC3);
        do_write(2'd2, 2'b11, 8'hFF);
        check("toggle", 32'(contents[23:16]), 32'h3C);

        // Same-cycle read and write returns pre-write value
        do_write(2'd0, 2'b00, 8'h11);
        addr = 2'd0; mode = 2'b00; data_in = 8'h22;
        write_strobe = 1'b1; read_strobe = 1'b1;
        tick();
        check("rw_old", 32'(read_data), 32'h11);
        check("rw_reg", 32'(contents[7:0]), 32'h22);
        write_strobe = 1'b0; read_strobe = 1'b0;
        tick();
        do_read(2'd0);
        check("rw_later", 32'(read_data), 32'h22);
        check("changed_all", 32'(changed), 32'(c_FMASK & 3'b111));

        // Changed flag: set wins over ack, ack clears, same-value write doesn't set
        changed_ack = '1; tick(); changed_ack = '0;
        check("ack_all", 32'(changed), 32'h0);
        do_write(2'd0, 2'b00, 8'h11);
        check("chg_set", 32'(changed), 32'(c_FMASK & 3'b001));
        addr = 2'd0; mode = 2'b00; data_in = 8'h22; write_strobe = 1'b1; changed_ack = 3'b001;
        tick();
        check("set_wins", 32'(changed), 32'(c_FMASK & 3'b001));
        write_strobe = 1'b0; changed_ack = '0;
        tick();
        changed_ack = 3'b001; tick(); changed_ack = '0;
        check("ack_clear", 32'(changed), 32'h0);
        do_write(2'd0, 2'b00, 8'h22);
        check("same_val", 32'(changed), 32'h0);
        check("same_val_reg", 32'(contents[7:0]), 32'h22);

        // Unmapped address
        do_write(2'd3, 2'b00, 8'h77);
        check("oor_contents", 32'(contents), 32'h003C5A22);
        check("oor_changed", 32'(changed), 32'h0);
        do_read(2'd3);
        check("oor_read", 32'(read_data), 32'h0);
        do_read(2'd1);
        check("read1", 32'(read_data), 32'h5A);

        // Strobe held across reset
        addr = 2'd1; mode = 2'b00; data_in = 8'h99; write_strobe = 1'b1;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick(); tick(); tick();
        check("rst_hold_contents", 32'(contents), 32'h0);
        check("rst_read_data", 32'(read_data), 32'h0);
        write_strobe = 1'b0; tick();
        write_strobe = 1'b1; tick();
        check("rst_rewrite", 32'(contents[15:8]), 32'h99);
        check("rst_changed", 32'(changed), 32'(c_FMASK & 3'b010));
        write_strobe = 1'b0; tick();

        // Back-to-back fires: high, low, high
        addr = 2'd2; mode = 2'b11; data_in = 8'h01; write_strobe = 1'b1;
        tick();
        check("b2b_first", 32'(contents[23:16]), 32'h01);
        write_strobe = 1'b0; tick();
        write_strobe = 1'b1; tick();
        check("b2b_second", 32'(contents[23:16]), 32'h00);
        check("b2b_changed", 32'(changed), 32'(c_FMASK & 3'b110));
        write_strobe = 1'b0; tick();

        $display("test done: total=%0d bad=%0d", r_total, r_bad);
        $finish;
    end

endmodule
`default_nettype wire
